// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: counters, syncs, blank, frame bookkeeping.
// Optional VGA_SYNC_DELAY_EN lags hs/vs by one clock behind DrawX/DrawY.
module vga_timing_gen #(
  parameter int   H_VISIBLE   = 640,
  parameter int   H_FP        = 16,
  parameter int   H_SYNC      = 96,
  parameter int   H_BP        = 48,
  parameter int   V_VISIBLE   = 480,
  parameter int   V_FP        = 10,
  parameter int   V_SYNC      = 2,
  parameter int   V_BP        = 33,
  parameter logic SYNC_ACTIVE = 1'b0
) (
  input  logic       vga_clk,
  input  logic       reset_n,
  output logic       hs,
  output logic       vs,
  output logic       blank,
  output logic [9:0] DrawX,
  output logic [9:0] DrawY,
  output logic       frame_start,
  output logic [7:0] frame_count
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > 1024) begin : g_h_chk
    $error("vga_timing_gen: H_TOTAL exceeds 1024");
  end
  if (V_TOTAL > 1024) begin : g_v_chk
    $error("vga_timing_gen: V_TOTAL exceeds 1024");
  end

  localparam logic [9:0]  H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST = 10'(V_TOTAL - 1);
  // 11-bit bounds so a 1024 total cannot wrap the compare limits
  localparam logic [10:0] HV  = 11'(H_VISIBLE);
  localparam logic [10:0] HS0 = 11'(H_VISIBLE + H_FP);
  localparam logic [10:0] HS1 = 11'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [10:0] VV  = 11'(V_VISIBLE);
  localparam logic [10:0] VS0 = 11'(V_VISIBLE + V_FP);
  localparam logic [10:0] VS1 = 11'(V_VISIBLE + V_FP + V_SYNC);

  typedef enum logic {
    PRIME,
    RUN
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [9:0]  x_nxt;
  logic [9:0]  y_nxt;
  logic [7:0]  fc_nxt;
  logic [10:0] xe;
  logic [10:0] ye;
  logic        hs_nxt;
  logic        vs_nxt;
  logic        blank_nxt;
  logic        fs_nxt;
  logic        hs_q;
  logic        vs_q;

  always_comb begin
    state_nxt = state;
    x_nxt     = DrawX;
    y_nxt     = DrawY;
    fc_nxt    = frame_count;
    unique case (state)
      PRIME: begin
        x_nxt     = 10'd0;
        y_nxt     = 10'd0;
        state_nxt = RUN;
      end
      RUN: begin
        if (DrawX == H_LAST) begin
          x_nxt = 10'd0;
          if (DrawY == V_LAST) begin
            y_nxt  = 10'd0;
            fc_nxt = frame_count + 8'd1;
          end else begin
            y_nxt = DrawY + 10'd1;
          end
        end else begin
          x_nxt = DrawX + 10'd1;
        end
      end
      default: state_nxt = PRIME;
    endcase
  end

  // Flags decode the next position so they land with the counters
  always_comb begin
    xe        = {1'b0, x_nxt};
    ye        = {1'b0, y_nxt};
    blank_nxt = (xe < HV) && (ye < VV);
    hs_nxt    = (xe >= HS0 && xe < HS1) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    vs_nxt    = (ye >= VS0 && ye < VS1) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    fs_nxt    = (x_nxt == 10'd0) && (y_nxt == 10'd0);
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= PRIME;
      DrawX       <= 10'd0;
      DrawY       <= 10'd0;
      frame_count <= 8'd0;
      blank       <= 1'b0;
      frame_start <= 1'b0;
      hs_q        <= ~SYNC_ACTIVE;
      vs_q        <= ~SYNC_ACTIVE;
    end else begin
      state       <= state_nxt;
      DrawX       <= x_nxt;
      DrawY       <= y_nxt;
      frame_count <= fc_nxt;
      blank       <= blank_nxt;
      frame_start <= fs_nxt;
      hs_q        <= hs_nxt;
      vs_q        <= vs_nxt;
    end
  end

`ifdef VGA_SYNC_DELAY_EN
  logic hs_d;
  logic vs_d;

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hs_d <= ~SYNC_ACTIVE;
      vs_d <= ~SYNC_ACTIVE;
    end else begin
      hs_d <= hs_q;
      vs_d <= vs_q;
    end
  end

  assign hs = hs_d;
  assign vs = vs_d;
`else
  assign hs = hs_q;
  assign vs = vs_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default, medium and tiny geometries.
// Cycle-by-cycle model compare plus table and corner sequences.
module tb_vga_timing_gen;

  localparam logic SA = 1'b0;
`ifdef VGA_SYNC_DELAY_EN
  localparam int LAG = 1;
`else
  localparam int LAG = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rd, rm, rs;

  logic       d_hs, d_vs, d_blank, d_fs;
  logic [9:0] d_x, d_y;
  logic [7:0] d_fc;
  logic       m_hs, m_vs, m_blank, m_fs;
  logic [9:0] m_x, m_y;
  logic [7:0] m_fc;
  logic       s_hs, s_vs, s_blank, s_fs;
  logic [9:0] s_x, s_y;
  logic [7:0] s_fc;

  vga_timing_gen u_d (
    .vga_clk(clk), .reset_n(rd),
    .hs(d_hs), .vs(d_vs), .blank(d_blank),
    .DrawX(d_x), .DrawY(d_y),
    .frame_start(d_fs), .frame_count(d_fc)
  );

  vga_timing_gen #(
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_m (
    .vga_clk(clk), .reset_n(rm),
    .hs(m_hs), .vs(m_vs), .blank(m_blank),
    .DrawX(m_x), .DrawY(m_y),
    .frame_start(m_fs), .frame_count(m_fc)
  );

  vga_timing_gen #(
    .H_VISIBLE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_VISIBLE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
  ) u_s (
    .vga_clk(clk), .reset_n(rs),
    .hs(s_hs), .vs(s_vs), .blank(s_blank),
    .DrawX(s_x), .DrawY(s_y),
    .frame_start(s_fs), .frame_count(s_fc)
  );

  logic [31:0] dv, mv, sv;
  assign dv = {d_hs, d_vs, d_blank, d_fs, d_fc, d_x, d_y};
  assign mv = {m_hs, m_vs, m_blank, m_fs, m_fc, m_x, m_y};
  assign sv = {s_hs, s_vs, s_blank, s_fs, s_fc, s_x, s_y};

  int n_chk = 0;
  int n_fail = 0;

  // cycles since release: -1 while in reset, 0 on the first run cycle
  int nd, nm, ns;
  always @(posedge clk or negedge rd) if (!rd) nd <= -1; else nd <= nd + 1;
  always @(posedge clk or negedge rm) if (!rm) nm <= -1; else nm <= nm + 1;
  always @(posedge clk or negedge rs) if (!rs) ns <= -1; else ns <= ns + 1;

  function automatic logic [31:0] expv(input int n,
      input int hv, input int hf, input int hw, input int hb,
      input int vv, input int vf, input int vw, input int vb);
    int ht, vt, x, y, f, p, px, py;
    logic h, v, b, s;
    if (n < 0) return {~SA, ~SA, 30'd0};
    ht = hv + hf + hw + hb;
    vt = vv + vf + vw + vb;
    x = n % ht;
    y = (n / ht) % vt;
    f = (n / (ht * vt)) % 256;
    b = (x < hv) && (y < vv);
    s = (x == 0) && (y == 0);
    p = n - LAG;
    if (p < 0) begin
      h = ~SA;
      v = ~SA;
    end else begin
      px = p % ht;
      py = (p / ht) % vt;
      h = (px >= hv + hf && px < hv + hf + hw) ? SA : ~SA;
      v = (py >= vv + vf && py < vv + vf + vw) ? SA : ~SA;
    end
    return {h, v, b, s, 8'(f), 10'(x), 10'(y)};
  endfunction

  task automatic chk(input string name, input int n,
                     input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s n=%0d got=%h want=%h", name, n, act, exp);
    end
  endtask

  always @(negedge clk) begin
    chk("d_cycle", nd, dv, expv(nd, 640, 16, 96, 48, 480, 10, 2, 33));
    chk("m_cycle", nm, mv, expv(nm, 640, 16, 96, 48, 4, 1, 1, 1));
    chk("s_cycle", ns, sv, expv(ns, 8, 1, 2, 1, 4, 1, 1, 1));
  end

  typedef struct {
    int         n;
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       blank;
    logic       fs;
  } vec_t;

  vec_t tbl[12];
  int   g, cnt, vsa, bl, dly;

  initial begin
    tbl[0]  = '{0,   10'd0,   10'd0, ~SA, 1'b1, 1'b1};
    tbl[1]  = '{1,   10'd1,   10'd0, ~SA, 1'b1, 1'b0};
    tbl[2]  = '{639, 10'd639, 10'd0, ~SA, 1'b1, 1'b0};
    tbl[3]  = '{640, 10'd640, 10'd0, ~SA, 1'b0, 1'b0};
    tbl[4]  = '{655, 10'd655, 10'd0, ~SA, 1'b0, 1'b0};
    tbl[5]  = '{656, 10'd656, 10'd0, (LAG == 1) ? ~SA : SA, 1'b0, 1'b0};
    tbl[6]  = '{657, 10'd657, 10'd0, SA,  1'b0, 1'b0};
    tbl[7]  = '{751, 10'd751, 10'd0, SA,  1'b0, 1'b0};
    tbl[8]  = '{752, 10'd752, 10'd0, (LAG == 1) ? SA : ~SA, 1'b0, 1'b0};
    tbl[9]  = '{753, 10'd753, 10'd0, ~SA, 1'b0, 1'b0};
    tbl[10] = '{799, 10'd799, 10'd0, ~SA, 1'b0, 1'b0};
    tbl[11] = '{800, 10'd0,   10'd1, ~SA, 1'b1, 1'b0};

    rd = 1'b0; rm = 1'b0; rs = 1'b0;
    repeat (5) @(negedge clk);
    chk("reset_vals", nd, dv, {~SA, ~SA, 30'd0});
    rd = 1'b1; rm = 1'b1; rs = 1'b1;

    for (int i = 0; i < 12; i++) begin
      g = 0;
      while (nd != tbl[i].n && g < 5000) begin
        @(negedge clk);
        g++;
      end
      chk("tbl_vec", tbl[i].n,
          {9'd0, d_x, d_y, d_hs, d_blank, d_fs},
          {9'd0, tbl[i].x, tbl[i].y, tbl[i].hs, tbl[i].blank, tbl[i].fs});
    end

    g = 0;
    while (m_fs !== 1'b1 && g < 10000) begin
      @(negedge clk);
      g++;
    end
    chk("m_fc_first_wrap", nm, {24'd0, m_fc}, 32'd1);
    cnt = 0; vsa = 0; bl = 0;
    do begin
      if (m_vs === SA) vsa++;
      if (m_blank === 1'b1) bl++;
      cnt++;
      @(negedge clk);
    end while (m_fs !== 1'b1 && cnt < 10000);
    chk("m_frame_period", nm, cnt, 32'd5600);
    chk("m_vs_cycles", nm, vsa, 32'd800);
    chk("m_blank_cycles", nm, bl, 32'd2560);
    chk("m_fc_second", nm, {24'd0, m_fc}, 32'd2);

    g = 0;
    while (!(m_x == 10'd700 && m_y == 10'd5) && g < 10000) begin
      @(negedge clk);
      g++;
    end
    chk("m_in_sync", nm, {30'd0, m_hs, m_vs}, {30'd0, SA, SA});
    #2 rm = 1'b0;
    #1 chk("m_async_rst", nm, mv, {~SA, ~SA, 30'd0});
    repeat (2) @(negedge clk);
    rm = 1'b1;
    @(negedge clk);
    chk("m_restart0", nm, {20'd0, m_x, m_y}, 32'd0);
    chk("m_restart_fs", nm, {31'd0, m_fs}, 32'd1);
    @(negedge clk);
    chk("m_restart1", nm, {20'd0, m_x, m_y}, {20'd0, 10'd1, 10'd0});

    g = 0;
    while (!(s_fc == 8'd255 && s_fs === 1'b1) && g < 30000) begin
      @(negedge clk);
      g++;
    end
    chk("s_fc_255", ns, {24'd0, s_fc}, 32'd255);
    cnt = 0;
    do begin
      cnt++;
      @(negedge clk);
    end while (s_fs !== 1'b1 && cnt < 1000);
    chk("s_period", ns, cnt, 32'd84);
    chk("s_fc_wrap", ns, {24'd0, s_fc}, 32'd0);

    for (int i = 0; i < 10; i++) begin
      repeat ($urandom_range(5, 200)) @(negedge clk);
      dly = $urandom_range(1, 3);
      #(dly) rs = 1'b0;
      #1 chk("s_async_rst", ns, sv, {~SA, ~SA, 30'd0});
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rs = 1'b1;
    end
    repeat (200) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
